blockade_input_cond: RTL and testbench

- Input conditioning stage directly upstream of the blockade core's in1/in2 ports.
- Turns raw MiSTer joystick and coin bits into clean, frame-synchronous, active-low input bytes.
- Per input: two-flop synchronisation, tick-based debounce, opposing-direction cleanup.
- Coin gets a frame-timed pulse with holdoff, so held or bouncing buttons cannot over-credit.

---
 rtl/blockade_input_cond.sv | 252 +++++++++++++++++++++++++
 tb/tb_blockade_input_cond.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockade_input_cond.sv
// Input conditioning for the blockade core: synchronises raw joystick and
// coin bits, debounces them on a slow tick, removes opposing directions and
// presents frame-synchronous active-low bytes to the core's in1/in2 ports.
// Coin presses become a frame-timed pulse followed by a holdoff window.
module blockade_input_cond #(
    parameter int DEBOUNCE_DIV        = 1024,
    parameter int DEBOUNCE_CNT        = 3,
    parameter int COIN_PULSE_FRAMES   = 3,
    parameter int COIN_HOLDOFF_FRAMES = 8,
    parameter int SOCD_CLEAN          = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] p1_dir,
    input  logic [3:0] p2_dir,
    input  logic       coin_btn,
    input  logic       vblank,
    output logic [7:0] in1,
    output logic [7:0] in2,
    output logic       coin_active
);

    localparam int PRESC_W   = $clog2(DEBOUNCE_DIV);
    localparam int FRAME_MAX = (COIN_PULSE_FRAMES > COIN_HOLDOFF_FRAMES) ?
                               COIN_PULSE_FRAMES : COIN_HOLDOFF_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST     = PRESC_W'(DEBOUNCE_DIV - 1);
    localparam logic [2:0]         DB_TARGET      = 3'(DEBOUNCE_CNT);
    localparam logic [FRAME_W-1:0] PULSE_TARGET   = FRAME_W'(COIN_PULSE_FRAMES);
    localparam logic [FRAME_W-1:0] HOLDOFF_TARGET = FRAME_W'(COIN_HOLDOFF_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLDOFF,
        WAIT_REL
    } coinState_t;

    // Bit layout used everywhere inside: {coin, p2[3:0], p1[3:0]}
    logic [8:0]       rawBits;
    logic [8:0]       sync1_q;
    logic [8:0]       sync2_q;

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               debounceTick;

    logic [8:0]       level_q;
    logic [8:0]       level_d;
    logic [8:0][2:0]  cnt_q;
    logic [8:0][2:0]  cnt_d;

    logic             vblank_q;
    logic             frameTick;

    logic [3:0]       p1Clean;
    logic [3:0]       p2Clean;
    logic             coinDb;
    logic             coinDbPrev_q;
    logic             coinRise;

    logic [7:0]       in2_q;
    logic [7:0]       in2_d;

    coinState_t         state_q;
    coinState_t         state_d;
    logic [FRAME_W-1:0] frameCnt_q;
    logic [FRAME_W-1:0] frameCnt_d;
    logic [FRAME_W-1:0] frameInc;
    logic               coinActive_q;
    logic               coinActive_d;

    assign rawBits = {coin_btn, p2_dir, p1_dir};

    // Two-flop synchroniser for every asynchronous raw input bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawBits;
            sync2_q <= sync1_q;
        end
    end

    assign debounceTick = (presc_q == PRESC_LAST);

    // Free-running prescaler that wraps after its last count
    always_comb begin
        presc_d = debounceTick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Per-bit debounce: a new level is accepted only after enough consecutive differing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (debounceTick) begin
            for (int i = 0; i < 9; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if ((cnt_q[i] + 3'd1) == DB_TARGET) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    // Debounced levels and their stability counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // vblank history starts high so a vblank already active at reset release is not a new frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b1;
        end else begin
            vblank_q <= vblank;
        end
    end

    assign frameTick = vblank & ~vblank_q;

    // Opposing directions on one stick cancel each other out
    function automatic logic [3:0] socdFilter(input logic [3:0] dir);
        logic [3:0] res;
        res = dir;
        if (SOCD_CLEAN != 0) begin
            if (dir[3] && dir[1]) begin
                res[3] = 1'b0;
                res[1] = 1'b0;
            end
            if (dir[2] && dir[0]) begin
                res[2] = 1'b0;
                res[0] = 1'b0;
            end
        end
        return res;
    endfunction

    assign p1Clean = socdFilter(level_q[3:0]);
    assign p2Clean = socdFilter(level_q[7:4]);
    assign coinDb  = level_q[8];

    // Joystick byte only changes at the start of vblank so the core sees a stable frame
    always_comb begin
        in2_d = frameTick ? ~{p2Clean, p1Clean} : in2_q;
    end

    // Joystick output register and debounced coin history for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in2_q        <= 8'hFF;
            coinDbPrev_q <= 1'b0;
        end else begin
            in2_q        <= in2_d;
            coinDbPrev_q <= coinDb;
        end
    end

    assign coinRise = coinDb & ~coinDbPrev_q;
    assign frameInc = frameCnt_q + 1'b1;

    // Coin FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            frameCnt_q   <= '0;
            coinActive_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frameCnt_q   <= frameCnt_d;
            coinActive_q <= coinActive_d;
        end
    end

    // Coin FSM next state: a press starts the pulse, frames time the pulse and holdoff
    always_comb begin
        state_d    = state_q;
        frameCnt_d = frameCnt_q;
        case (state_q)
            IDLE: begin
                if (coinRise) begin
                    state_d    = PULSE;
                    frameCnt_d = '0;
                end
            end
            PULSE: begin
                if (frameTick) begin
                    if (frameInc == PULSE_TARGET) begin
                        frameCnt_d = '0;
                        if (COIN_HOLDOFF_FRAMES > 0) begin
                            state_d = HOLDOFF;
                        end else begin
                            state_d = WAIT_REL;
                        end
                    end else begin
                        frameCnt_d = frameInc;
                    end
                end
            end
            HOLDOFF: begin
                if (frameTick) begin
                    if (frameInc == HOLDOFF_TARGET) begin
                        state_d    = WAIT_REL;
                        frameCnt_d = '0;
                    end else begin
                        frameCnt_d = frameInc;
                    end
                end
            end
            WAIT_REL: begin
                if (!coinDb) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                frameCnt_d = '0;
            end
        endcase
    end

    // Coin FSM output: the pulse flag is registered alongside the state
    always_comb begin
        coinActive_d = (state_d == PULSE);
    end

    assign coin_active = coinActive_q;
    assign in1         = {~coinActive_q, 7'h7F};
    assign in2         = in2_q;

endmodule

// File: tb/tb_blockade_input_cond.sv
// Directed bench for blockade_input_cond with a short debounce tick so the
// timing can be followed clock by clock; a second instance has opposing
// direction cleanup disabled.
module tb_blockade_input_cond;

    logic       clk;
    logic       reset_n;
    logic [3:0] p1_dir;
    logic [3:0] p2_dir;
    logic       coin_btn;
    logic       vblank;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       coin_active;
    logic [7:0] in1B;
    logic [7:0] in2B;
    logic       coinActiveB;

    int compared;
    int mismatched;

    logic [7:0] preIn2;
    logic [7:0] snapIn1;
    logic [7:0] snapIn2;
    logic [7:0] snapIn2B;
    logic       snapCoin;

    blockade_input_cond #(
        .DEBOUNCE_DIV        (4),
        .DEBOUNCE_CNT        (3),
        .COIN_PULSE_FRAMES   (3),
        .COIN_HOLDOFF_FRAMES (8),
        .SOCD_CLEAN          (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p1_dir      (p1_dir),
        .p2_dir      (p2_dir),
        .coin_btn    (coin_btn),
        .vblank      (vblank),
        .in1         (in1),
        .in2         (in2),
        .coin_active (coin_active)
    );

    blockade_input_cond #(
        .DEBOUNCE_DIV        (4),
        .DEBOUNCE_CNT        (3),
        .COIN_PULSE_FRAMES   (3),
        .COIN_HOLDOFF_FRAMES (8),
        .SOCD_CLEAN          (0)
    ) dutNoSocd (
        .clk         (clk),
        .reset_n     (reset_n),
        .p1_dir      (p1_dir),
        .p2_dir      (p2_dir),
        .coin_btn    (coin_btn),
        .vblank      (vblank),
        .in1         (in1B),
        .in2         (in2B),
        .coin_active (coinActiveB)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached (compared %0d, mismatched %0d)", compared, mismatched);
        $fatal(1, "[TB] time limit");
    end

    task automatic waitClk();
        @(posedge clk);
        #1;
    endtask

    task automatic waitN(input int n);
        for (int i = 0; i < n; i++) begin
            waitClk();
        end
    endtask

    // One vblank rise; outputs captured one clock after the rise
    task automatic frameRise();
        preIn2 = in2;
        vblank = 1'b1;
        waitClk();
        snapIn1  = in1;
        snapIn2  = in2;
        snapIn2B = in2B;
        snapCoin = coin_active;
        waitClk();
        vblank = 1'b0;
        waitClk();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        p1_dir   = 4'h0;
        p2_dir   = 4'h0;
        coin_btn = 1'b0;
        vblank   = 1'b0;
        waitN(3);
        compared++;
        if (in1 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL reset_in1: got %h expected %h", in1, 8'hFF);
        end
        compared++;
        if (in2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL reset_in2: got %h expected %h", in2, 8'hFF);
        end
        compared++;
        if (coin_active !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_coin: got %b expected %b", coin_active, 1'b0);
        end
        compared++;
        if (in2B !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL reset_in2_nosocd: got %h expected %h", in2B, 8'hFF);
        end
        reset_n = 1'b1;
        waitN(2);
    endtask

    task automatic test_debounce();
        p1_dir = 4'b0001;
        waitClk();
        p1_dir = 4'b0000;
        waitN(8);
        p1_dir = 4'b0001;
        waitN(8);
        p1_dir = 4'b0000;
        waitN(10);
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL debounce_glitch: got %h expected %h", snapIn2, 8'hFF);
        end
        p1_dir = 4'b0001;
        waitN(20);
        frameRise();
        compared++;
        if (preIn2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL debounce_before_edge: got %h expected %h", preIn2, 8'hFF);
        end
        compared++;
        if (snapIn2 !== 8'hFE) begin
            mismatched++;
            $display("[TB] FAIL debounce_accept: got %h expected %h", snapIn2, 8'hFE);
        end
        p1_dir = 4'b0000;
        waitN(20);
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL debounce_release: got %h expected %h", snapIn2, 8'hFF);
        end
    endtask

    task automatic test_frame_sync();
        p2_dir = 4'b0010;
        waitN(20);
        compared++;
        if (in2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL frame_press_midframe: got %h expected %h", in2, 8'hFF);
        end
        frameRise();
        compared++;
        if (snapIn2 !== 8'hDF) begin
            mismatched++;
            $display("[TB] FAIL frame_press_edge: got %h expected %h", snapIn2, 8'hDF);
        end
        p2_dir = 4'b0000;
        waitN(20);
        compared++;
        if (in2 !== 8'hDF) begin
            mismatched++;
            $display("[TB] FAIL frame_release_midframe: got %h expected %h", in2, 8'hDF);
        end
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL frame_release_edge: got %h expected %h", snapIn2, 8'hFF);
        end
    endtask

    task automatic test_socd();
        p1_dir = 4'b1010;
        waitN(20);
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL socd_lr_clean: got %h expected %h", snapIn2, 8'hFF);
        end
        compared++;
        if (snapIn2B !== 8'hF5) begin
            mismatched++;
            $display("[TB] FAIL socd_lr_raw: got %h expected %h", snapIn2B, 8'hF5);
        end
        p1_dir = 4'b1110;
        waitN(20);
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFB) begin
            mismatched++;
            $display("[TB] FAIL socd_lr_down_clean: got %h expected %h", snapIn2, 8'hFB);
        end
        compared++;
        if (snapIn2B !== 8'hF1) begin
            mismatched++;
            $display("[TB] FAIL socd_lr_down_raw: got %h expected %h", snapIn2B, 8'hF1);
        end
        p1_dir = 4'b0000;
        p2_dir = 4'b0101;
        waitN(20);
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL socd_p2_ud_clean: got %h expected %h", snapIn2, 8'hFF);
        end
        compared++;
        if (snapIn2B !== 8'hAF) begin
            mismatched++;
            $display("[TB] FAIL socd_p2_ud_raw: got %h expected %h", snapIn2B, 8'hAF);
        end
        p2_dir = 4'b0000;
        waitN(20);
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFF || snapIn2B !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL socd_release: got %h/%h expected ff/ff", snapIn2, snapIn2B);
        end
    endtask

    task automatic test_coin_hold();
        int extraPulses;
        extraPulses = 0;
        coin_btn = 1'b1;
        waitN(20);
        compared++;
        if (coin_active !== 1'b1 || in1 !== 8'h7F) begin
            mismatched++;
            $display("[TB] FAIL coin_press: got active=%b in1=%h expected active=1 in1=7f", coin_active, in1);
        end
        compared++;
        if (coinActiveB !== 1'b1 || in1B !== 8'h7F) begin
            mismatched++;
            $display("[TB] FAIL coin_press_nosocd: got active=%b in1=%h expected active=1 in1=7f", coinActiveB, in1B);
        end
        for (int f = 1; f <= 50; f++) begin
            frameRise();
            if (f <= 2) begin
                compared++;
                if (snapIn1 !== 8'h7F) begin
                    mismatched++;
                    $display("[TB] FAIL coin_pulse_frame%0d: got %h expected %h", f, snapIn1, 8'h7F);
                end
            end else if (f == 3) begin
                compared++;
                if (snapIn1 !== 8'hFF || snapCoin !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL coin_pulse_end: got in1=%h active=%b expected in1=ff active=0", snapIn1, snapCoin);
                end
            end else if (snapCoin !== 1'b0) begin
                extraPulses++;
            end
        end
        compared++;
        if (extraPulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL coin_held_retrigger: got %0d active frames expected 0", extraPulses);
        end
        coin_btn = 1'b0;
        waitN(20);
        coin_btn = 1'b1;
        waitN(20);
        compared++;
        if (coin_active !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL coin_repress: got %b expected %b", coin_active, 1'b1);
        end
        for (int f = 1; f <= 3; f++) begin
            frameRise();
            compared++;
            if (snapCoin !== (f < 3)) begin
                mismatched++;
                $display("[TB] FAIL coin_repress_frame%0d: got %b expected %b", f, snapCoin, (f < 3));
            end
        end
    endtask

    task automatic test_holdoff_bounce();
        coin_btn = 1'b0;
        waitN(20);
        for (int f = 1; f <= 5; f++) begin
            frameRise();
        end
        coin_btn = 1'b1;
        waitN(20);
        compared++;
        if (coin_active !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL holdoff_press_ignored: got %b expected %b", coin_active, 1'b0);
        end
        for (int f = 1; f <= 3; f++) begin
            frameRise();
        end
        waitN(5);
        compared++;
        if (coin_active !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL holdoff_held_after: got %b expected %b", coin_active, 1'b0);
        end
        coin_btn = 1'b0;
        waitN(20);
        coin_btn = 1'b1;
        waitN(20);
        compared++;
        if (coin_active !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL holdoff_new_press: got %b expected %b", coin_active, 1'b1);
        end
        for (int f = 1; f <= 3; f++) begin
            frameRise();
        end
        compared++;
        if (snapCoin !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL holdoff_new_pulse_end: got %b expected %b", snapCoin, 1'b0);
        end
        coin_btn = 1'b0;
        waitN(4);
    endtask

    // From reset release, the debounced coin edge lands 12 clocks later
    task automatic test_vblank_coincident();
        coin_btn = 1'b0;
        p1_dir   = 4'h0;
        p2_dir   = 4'h0;
        vblank   = 1'b0;
        reset_n  = 1'b0;
        waitN(2);
        reset_n  = 1'b1;
        coin_btn = 1'b1;
        waitN(12);
        compared++;
        if (coin_active !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL coincident_before: got %b expected %b", coin_active, 1'b0);
        end
        vblank = 1'b1;
        waitClk();
        compared++;
        if (coin_active !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL coincident_entry: got %b expected %b", coin_active, 1'b1);
        end
        waitClk();
        vblank = 1'b0;
        waitClk();
        for (int f = 1; f <= 3; f++) begin
            frameRise();
            compared++;
            if (snapCoin !== (f < 3)) begin
                mismatched++;
                $display("[TB] FAIL coincident_frame%0d: got %b expected %b", f, snapCoin, (f < 3));
            end
        end
        coin_btn = 1'b0;
        waitN(4);
    endtask

    task automatic test_reset_mid_pulse();
        int riseAt;
        riseAt   = 0;
        reset_n  = 1'b0;
        coin_btn = 1'b1;
        p1_dir   = 4'b0001;
        waitN(2);
        reset_n = 1'b1;
        waitN(20);
        frameRise();
        compared++;
        if (snapIn2 !== 8'hFE || snapCoin !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midpulse_setup: got in2=%h active=%b expected in2=fe active=1", snapIn2, snapCoin);
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if (in1 !== 8'hFF || in2 !== 8'hFF || coin_active !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midpulse_async_reset: got in1=%h in2=%h active=%b expected ff ff 0", in1, in2, coin_active);
        end
        waitN(2);
        reset_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            waitClk();
            if (coin_active === 1'b1 && riseAt == 0) begin
                riseAt = n;
            end
        end
        compared++;
        if (riseAt != 13) begin
            mismatched++;
            $display("[TB] FAIL midpulse_rerise_clocks: got %0d expected %0d", riseAt, 13);
        end
        coin_btn = 1'b0;
        p1_dir   = 4'b0000;
        waitN(4);
    endtask

    // Test sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_debounce();
        test_frame_sync();
        test_socd();
        test_coin_hold();
        test_holdoff_bounce();
        test_vblank_coincident();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
